line_ram_ctrl: RTL

- Parametrised, multi-cycle, line-organised RAM that serves cache line fills and word write-backs over a mem_req/mem_ready handshake.
- Read returns one full line of LINE_WORDS words; write updates a single word.
- Access latency is programmable.
- Separate read and write buses; no tristate.
- Sits below the cache controller as its backing memory model/synthesizable store.

---
 rtl/line_ram_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/line_ram_ctrl.sv
// Line-organised backing RAM: full-line reads, single-word writes, fixed
// programmable access latency behind a mem_req/mem_ready handshake.
module line_ram_ctrl #(
  parameter int WORD_W     = 10,
  parameter int ADDR_W     = 10,
  parameter int LINE_WORDS = 2,
  parameter int LATENCY    = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mem_req,
  input  logic                         we,
  input  logic [ADDR_W-1:0]            address,
  input  logic [WORD_W-1:0]            wdata,
  output logic                         mem_ready,
  output logic [LINE_WORDS*WORD_W-1:0] rdata,
  output logic                         rvalid
);

  localparam int OFF   = $clog2(LINE_WORDS);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, EXEC} state_t;

  state_t                        state_q, state_d;
  logic                          we_q, we_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic [WORD_W-1:0]             wdata_q, wdata_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [LINE_WORDS*WORD_W-1:0]  rdata_q, rdata_d;
  logic                          rvalid_q, rvalid_d;
  logic [ADDR_W-1:0]             line_base;
  logic                          mem_wr;

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Storage is deliberately left unreset; an aborted write never reaches it
  // because reset forces the FSM out of EXEC.
  always_ff @(posedge clk) begin
    if (mem_wr) mem_q[addr_q] <= wdata_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_req) state_d = (LATENCY > 1) ? WAIT : EXEC;
      WAIT:    if (cnt_q == CNT_W'(1)) state_d = EXEC;
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign line_base = {addr_q[ADDR_W-1:OFF], {OFF{1'b0}}};

  always_comb begin
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (state_q == IDLE && mem_req) begin
      we_d    = we;
      addr_d  = address;
      wdata_d = wdata;
      cnt_d   = CNT_W'(LATENCY - 1);
    end
    if (state_q == WAIT) cnt_d = cnt_q - CNT_W'(1);
    // Read path gathers the whole aligned line in the completion cycle.
    if (state_q == EXEC && !we_q) begin
      for (int j = 0; j < LINE_WORDS; j++) begin
        rdata_d[j*WORD_W +: WORD_W] = mem_q[line_base + ADDR_W'(j)];
      end
      rvalid_d = 1'b1;
    end
  end

  always_comb begin
    mem_ready = (state_q == IDLE);
    mem_wr    = (state_q == EXEC) && we_q;
    rdata     = rdata_q;
    rvalid    = rvalid_q;
  end

endmodule
